// File: rtl/venera_pkg.sv
// Shared encodings for venera_cpu_1: opcodes, ALU operation codes, trap vector and decode FSM states.
// Combinational helpers only; no timing or flow-control behaviour lives here.
package venera_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_JNZ  = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_LDI = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;

    localparam logic [7:0] TRAP_VECTOR = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_ISSUE  = 2'd3
    } state_t;

    function automatic logic [2:0] alu_op_of(input logic [3:0] opcode);
        logic [2:0] op;
        op = ALU_LDI;
        case (opcode)
            OP_ADD:  op = ALU_ADD;
            OP_SUB:  op = ALU_SUB;
            OP_AND:  op = ALU_AND;
            OP_OR:   op = ALU_OR;
            OP_XOR:  op = ALU_XOR;
            default: op = ALU_LDI;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instruction_opcode_decode.sv
// Combinational opcode -> control-class lookup; zero latency, no flow control.
// INSTRUCTION_DECODER_ILLEGAL_TRAP_EN flags opcodes B-E as illegal; otherwise they fall through as NOP.
module instruction_opcode_decode
    import venera_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_jmp,
    output logic       is_jz,
    output logic       is_jnz,
    output logic       is_out,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        is_alu     = 1'b0;
        is_jmp     = 1'b0;
        is_jz      = 1'b0;
        is_jnz     = 1'b0;
        is_out     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_LDI, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_XOR: is_alu  = 1'b1;
            OP_JMP:                is_jmp  = 1'b1;
            OP_JZ:                 is_jz   = 1'b1;
            OP_JNZ:                is_jnz  = 1'b1;
            OP_OUT:                is_out  = 1'b1;
            OP_HALT:               is_halt = 1'b1;
`ifdef INSTRUCTION_DECODER_ILLEGAL_TRAP_EN
            4'hB, 4'hC, 4'hD, 4'hE: is_illegal = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_decoder.sv
// Fetch-side decode: rd in T, ROM data captured T+1, decoded T+2, registered one-cycle pulses in T+3; rd outside IDLE is ignored.
// INSTRUCTION_DECODER_ILLEGAL_TRAP_EN: opcodes B-E pulse illegal and jump to TRAP_VECTOR; otherwise they act as NOP.
module instruction_decoder
    import venera_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rd,
    input  logic [ADDR_W-1:0]  address,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               zero_flag,
    output logic               set_valid,
    output logic [ADDR_W-1:0]  set_value,
    output logic               alu_valid,
    output logic [2:0]         alu_op,
    output logic [7:0]         alu_imm,
    output logic               out_valid,
    output logic               halted,
    output logic               illegal
);

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [3:0]          opcode_q;
    logic [7:0]          operand_q;
    logic                set_valid_q;
    logic [ADDR_W-1:0]   set_value_q;
    logic                alu_valid_q;
    logic [2:0]          alu_op_q;
    logic [7:0]          alu_imm_q;
    logic                out_valid_q;
    logic                halted_q;
    logic                illegal_q;

    logic is_alu, is_jmp, is_jz, is_jnz, is_out, is_halt, is_illegal;
    logic take_jump;

    // Reserved instruction bits carry no meaning for this decoder.
    logic unused_rsvd;
    assign unused_rsvd = ^rom_data[INSTR_W-5:8];

    instruction_opcode_decode u_opcode_decode (
        .opcode     (opcode_q),
        .is_alu     (is_alu),
        .is_jmp     (is_jmp),
        .is_jz      (is_jz),
        .is_jnz     (is_jnz),
        .is_out     (is_out),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    assign take_jump = is_jmp | (is_jz & zero_flag) | (is_jnz & ~zero_flag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            opcode_q    <= '0;
            operand_q   <= '0;
            set_valid_q <= 1'b0;
            set_value_q <= '0;
            alu_valid_q <= 1'b0;
            alu_op_q    <= '0;
            alu_imm_q   <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            set_valid_q <= 1'b0;
            alu_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rd) begin
                        pc_q    <= address;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    opcode_q  <= rom_data[INSTR_W-1 -: 4];
                    operand_q <= rom_data[7:0];
                    state_q   <= ST_DECODE;
                end
                ST_DECODE: begin
                    state_q <= ST_ISSUE;
                    // Once halted, every fetch spins on its own address regardless of content.
                    if (halted_q || is_halt) begin
                        halted_q    <= 1'b1;
                        set_valid_q <= 1'b1;
                        set_value_q <= pc_q;
                    end else if (is_alu) begin
                        alu_valid_q <= 1'b1;
                        alu_op_q    <= alu_op_of(opcode_q);
                        alu_imm_q   <= operand_q;
                    end else if (take_jump) begin
                        set_valid_q <= 1'b1;
                        set_value_q <= ADDR_W'(operand_q);
                    end else if (is_out) begin
                        out_valid_q <= 1'b1;
                        alu_imm_q   <= operand_q;
                    end else if (is_illegal) begin
                        illegal_q   <= 1'b1;
                        set_valid_q <= 1'b1;
                        set_value_q <= ADDR_W'(TRAP_VECTOR);
                    end
                end
                ST_ISSUE: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign set_valid = set_valid_q;
    assign set_value = set_value_q;
    assign alu_valid = alu_valid_q;
    assign alu_op    = alu_op_q;
    assign alu_imm   = alu_imm_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder; acts as address counter and ROM, predicts T+3 outputs.
module tb_instruction_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic [7:0]  address;
    logic [15:0] rom_data;
    logic        zero_flag;
    logic        set_valid;
    logic [7:0]  set_value;
    logic        alu_valid;
    logic [2:0]  alu_op;
    logic [7:0]  alu_imm;
    logic        out_valid;
    logic        halted;
    logic        illegal;

    instruction_decoder #(.INSTR_W(16), .ADDR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd        (rd),
        .address   (address),
        .rom_data  (rom_data),
        .zero_flag (zero_flag),
        .set_valid (set_valid),
        .set_value (set_value),
        .alu_valid (alu_valid),
        .alu_op    (alu_op),
        .alu_imm   (alu_imm),
        .out_valid (out_valid),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       sv;
        logic [7:0] sval;
        logic       av;
        logic [2:0] aop;
        logic [7:0] aimm;
        logic       ov;
        logic       h;
        logic       il;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         mon_en = 0;
    bit         rd_real = 0;
    logic       halted_m = 1'b0;
    logic       halted_exp = 1'b0;
    logic [7:0] exp_next = 8'h00;
    logic [7:0] ctr;

    always @(posedge clk) cyc <= cyc + 1;

    // Address counter: advances on each real fetch, loads on a jump request.
    always @(posedge clk or posedge reset) begin
        if (reset)          ctr <= 8'h00;
        else if (set_valid) ctr <= set_value;
        else if (rd_real)   ctr <= ctr + 8'h01;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_set_valid", {31'd0, set_valid}, 0);
        check("rst_set_value", {24'd0, set_value}, 0);
        check("rst_alu_valid", {31'd0, alu_valid}, 0);
        check("rst_alu_op",    {29'd0, alu_op},    0);
        check("rst_alu_imm",   {24'd0, alu_imm},   0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_halted",    {31'd0, halted},    0);
        check("rst_illegal",   {31'd0, illegal},   0);
    endtask

    function automatic exp_t model(input logic [15:0] instr, input logic zf, input logic [7:0] pc);
        exp_t       e;
        logic [3:0] op;
        logic [7:0] opd;
        op  = instr[15:12];
        opd = instr[7:0];
        e   = '{cyc: 0, sv: 1'b0, sval: 8'h00, av: 1'b0, aop: 3'd0, aimm: 8'h00, ov: 1'b0, h: 1'b0, il: 1'b0};
        if (halted_m || op == 4'hF) begin
            halted_m = 1'b1;
            e.h      = 1'b1;
            e.sv     = 1'b1;
            e.sval   = pc;
        end else begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                    e.av   = 1'b1;
                    e.aop  = 3'(op - 4'd1);
                    e.aimm = opd;
                end
                4'h7: begin e.sv = 1'b1; e.sval = opd; end
                4'h8: if (zf)  begin e.sv = 1'b1; e.sval = opd; end
                4'h9: if (!zf) begin e.sv = 1'b1; e.sval = opd; end
                4'hA: begin e.ov = 1'b1; e.aimm = opd; end
`ifdef INSTRUCTION_DECODER_ILLEGAL_TRAP_EN
                4'hB, 4'hC, 4'hD, 4'hE: begin e.il = 1'b1; e.sv = 1'b1; e.sval = 8'hFF; end
`endif
                default: ;
            endcase
        end
        exp_next = e.sv ? e.sval : pc + 8'h01;
        return e;
    endfunction

    // One 4-cycle fetch period starting at cycle T; optional stray rd in T+1/T+2 and reset during DECODE.
    task automatic fetch(input logic [15:0] instr, input logic zf, input bit extra_rd, input bit rst_mid);
        exp_t       e;
        logic [7:0] a;
        @(posedge clk); #1;
        a = ctr;
        check("fetch_addr", {24'd0, a}, {24'd0, exp_next});
        rd      = 1'b1;
        rd_real = 1;
        address = a;
        if (!rst_mid) begin
            e     = model(instr, zf, a);
            e.cyc = cyc + 3;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        rd_real   = 0;
        rd        = extra_rd;
        address   = a + 8'h55;
        rom_data  = instr;
        zero_flag = zf;
        @(posedge clk); #1;
        rd = extra_rd;
        if (rst_mid) begin
            reset      = 1'b1;
            halted_m   = 1'b0;
            halted_exp = 1'b0;
            exp_next   = 8'h00;
        end
        @(posedge clk); #1;
        rd = 1'b0;
        if (rst_mid) begin
            check_reset_vals();
            reset = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check("set_valid", {31'd0, set_valid}, {31'd0, e.sv});
                if (e.sv) check("set_value", {24'd0, set_value}, {24'd0, e.sval});
                check("alu_valid", {31'd0, alu_valid}, {31'd0, e.av});
                if (e.av) begin
                    check("alu_op",  {29'd0, alu_op},  {29'd0, e.aop});
                    check("alu_imm", {24'd0, alu_imm}, {24'd0, e.aimm});
                end
                check("out_valid", {31'd0, out_valid}, {31'd0, e.ov});
                if (e.ov) check("out_imm", {24'd0, alu_imm}, {24'd0, e.aimm});
                check("halted", {31'd0, halted}, {31'd0, e.h});
                check("illegal", {31'd0, illegal}, {31'd0, e.il});
                if (e.h) halted_exp = 1'b1;
            end else begin
                check("idle_pulses", {28'd0, set_valid, alu_valid, out_valid, illegal}, 0);
                check("idle_halted", {31'd0, halted}, {31'd0, halted_exp});
            end
        end
    end

    initial begin
        reset     = 1'b1;
        rd        = 1'b0;
        address   = 8'h00;
        rom_data  = 16'h0000;
        zero_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset  = 1'b0;
        mon_en = 1;

        fetch(16'h7040, 1'b0, 0, 1);
        fetch(16'h1005, 1'b0, 0, 0);
        fetch(16'h7023, 1'b0, 0, 0);
        fetch(16'h8010, 1'b1, 0, 0);
        fetch(16'h8010, 1'b0, 0, 0);
        fetch(16'h9033, 1'b0, 0, 0);
        fetch(16'h9033, 1'b1, 0, 0);
        for (int op = 1; op <= 6; op++)
            fetch({4'(op), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))}, 1'($urandom_range(0, 1)), 0, 0);
        fetch(16'hA05A, 1'b0, 0, 0);
        fetch(16'h0123, 1'b1, 0, 0);
        fetch(16'hB000, 1'b0, 0, 0);
        fetch(16'hE0C3, 1'b1, 0, 0);
        fetch(16'h6077, 1'b0, 1, 0);
        fetch(16'h7007, 1'b0, 0, 0);
        fetch(16'hF000, 1'b0, 0, 0);
        fetch(16'h1005, 1'b0, 0, 0);
        fetch(16'hA011, 1'b1, 0, 0);
        fetch(16'h7020, 1'b0, 1, 0);

        @(posedge clk); #1;
        reset      = 1'b1;
        halted_m   = 1'b0;
        halted_exp = 1'b0;
        exp_next   = 8'h00;
        #2;
        check_reset_vals();
        @(posedge clk); #1;
        reset = 1'b0;
        fetch(16'h40A5, 1'b0, 0, 0);
        fetch(16'h0000, 1'b0, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Fetch-side decode stage of venera_cpu_1, directly downstream of the address counter. It consumes the counter's `rd` strobe and `address`, captures the 16-bit instruction returned by the synchronous program ROM, and decodes it. It then issues one-cycle control pulses to the ALU and output port, and drives jumps back into the counter through `set_valid`/`set_value`. One instruction is processed per 4-clock fetch period.

## Interface
Parameters:
- `INSTR_W`, 16, instruction width; opcode in [15:12], reserved [11:8], operand [7:0]
- `ADDR_W`, 8, program address width; must match address counter

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `rd`  in  1  fetch strobe from address counter, one cycle every 4 clocks
- `address`  in  ADDR_W  fetch address, valid in the `rd` cycle
- `rom_data`  in  INSTR_W  ROM read data, valid the cycle after `rd`
- `zero_flag`  in  1  ALU zero flag
- `set_valid`  out  1  one-cycle jump request to address counter
- `set_value`  out  ADDR_W  jump target
- `alu_valid`  out  1  one-cycle ALU operation strobe
- `alu_op`  out  3  0 LDI, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
- `alu_imm`  out  8  immediate operand
- `out_valid`  out  1  one-cycle OUT strobe
- `halted`  out  1  sticky halt indicator
- `illegal`  out  1  one-cycle illegal-opcode pulse (tied 0 without macro)

## Operation
- Opcodes: 0 NOP, 1 LDI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 JMP, 8 JZ, 9 JNZ, A OUT, F HALT; B–E undefined.
- FSM: IDLE -> FETCH -> DECODE -> ISSUE -> IDLE.
  - IDLE: on `rd`, capture `address` into `pc_q`, then go to FETCH.
  - FETCH: latch `rom_data` into the instruction register.
  - DECODE: sample `zero_flag`, then register the outputs.
  - ISSUE: all pulses high for exactly this cycle, then return to IDLE.
- ALU opcodes 1–6: `alu_valid`=1, `alu_op`=opcode−1, `alu_imm`=operand.
- JMP: `set_valid`=1, `set_value`=operand.
- JZ and JNZ: jump only if `zero_flag` (sampled in DECODE) is 1 or 0 respectively; otherwise no pulse.
- OUT: `out_valid`=1, `alu_imm`=operand.
- NOP: no pulses.
- HALT: `halted` is set in ISSUE and stays set until reset.
  - While halted, every subsequent fetch is decoded as a self-jump: `set_valid`=1, `set_value`=`pc_q`. Instruction content is ignored, and no ALU/OUT pulses are issued.
  - The HALT fetch itself also issues the self-jump, to its own `pc_q`.
- `rd` asserted outside IDLE is ignored.
- Undefined opcodes: behaviour set by the configuration macro.
- Non-pulse outputs (`alu_op`, `alu_imm`, `set_value`) hold their last value between ISSUE cycles.

## Timing
- `rd` in cycle T, FETCH in T+1, DECODE in T+2, ISSUE in T+3. All outputs are registered and pulse in T+3.
- The jump in T+3 loads the counter at the end of T+3, so the next `rd` (T+4) fetches the target with no lost or extra fetch.
- At most one of `set_valid`, `alu_valid`, `out_valid` is high in any cycle.
- Reset (asynchronous, any state) forces:
  - FSM to IDLE;
  - all outputs, `pc_q` and the instruction register to 0;
  - `halted` to 0.
  
  An in-flight instruction is dropped without any pulse.
- First `rd` after reset deassertion is processed normally.

## Configuration
- `INSTRUCTION_DECODER_ILLEGAL_TRAP_EN` defined: opcodes B–E cause `illegal`=1 and a jump (`set_valid`=1, `set_value`=8'hFF) in ISSUE.
- Not defined: B–E decode as NOP, and `illegal` is constant 0.

## Structure
- Shared package `venera_pkg` holds:
  - opcode localparams;
  - ALU op encodings;
  - `TRAP_VECTOR` = 8'hFF;
  - FSM state typedef.
- One sub-module, `instruction_opcode_decode`: combinational opcode -> control-bit lookup (`is_alu`, `is_jmp`, `is_jz`, `is_jnz`, `is_out`, `is_halt`, `is_illegal`). The FSM and registers stay in the top.

## Test plan
- Reset mid-DECODE holding JMP 8'h40 -> no `set_valid`; all outputs 0; the next `rd` with ROM 16'h1005 gives `alu_valid`, `alu_op`=0, `alu_imm`=8'h05 at T+3.
- ROM 16'h7023 at `rd` T -> `set_valid`=1, `set_value`=8'h23 only in T+3; the next `rd` presents address 8'h23.
- JZ 16'h8010 with `zero_flag`=1 -> jump to 8'h10; with `zero_flag`=0 -> no pulses.
- HALT fetched at address 8'h07 -> `halted`=1 from T+3. The next three fetches each give `set_valid` with `set_value`=8'h07 and no ALU pulses.
- ROM 16'hB000 -> with macro: `illegal`=1 and jump to 8'hFF; without macro: no pulses.
- `rd` asserted again at T+1 and T+2 -> ignored; the instruction from T completes in T+3 unaffected.
